// File: rtl/cipher_dispatch.sv
// Buffers the serial message stream in a FIFO and forwards each whole message,
// token included, to the selected decryption engine, waiting out the engine's busy.
module cipher_dispatch #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 DEPTH                  = 64,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA,
  parameter int                 BUSY_TIMEOUT           = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  input  logic [1:0]         sel_i,
  output logic               ready_o,
  input  logic [2:0]         busy_i,
  output logic [D_WIDTH-1:0] data_o,
  output logic [2:0]         valid_o,
  output logic               dropped_o,
  output logic               busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = D_WIDTH + 2;
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, DROP} state_t;

  // The head entry must be visible in the same cycle it is popped, so reads are asynchronous.
  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [EW-1:0]      head;
  logic [1:0]         head_sel;
  logic [D_WIDTH-1:0] head_data;
  logic [3:0]         busy_ext;

  state_t             state;
  logic [1:0]         cur_sel;
  logic [TW-1:0]      timer;

  function automatic logic [2:0] one_hot(input logic [1:0] s);
    logic [2:0] r;
    r = 3'b000;
    case (s)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign ready_o   = !full;
  assign push      = valid_i && !full;
  assign pop       = !empty && ((state == SEND) || (state == DROP));
  assign head      = mem[rd_ptr];
  assign head_sel  = head[EW-1 -: 2];
  assign head_data = head[D_WIDTH-1:0];
  assign busy_ext  = {1'b0, busy_i};
  assign busy_o    = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {sel_i, data_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_sel   <= 2'd0;
      timer     <= '0;
      data_o    <= '0;
      valid_o   <= 3'b000;
      dropped_o <= 1'b0;
    end else begin
      valid_o   <= 3'b000;
      dropped_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            cur_sel <= head_sel;
            if (head_sel == 2'd3)          state <= DROP;
            else if (!busy_ext[head_sel])  state <= SEND;
          end
        end
        SEND: begin
          if (!empty) begin
            data_o  <= head_data;
            valid_o <= one_hot(cur_sel);
            if (head_data == START_DECRYPTION_TOKEN) begin
              state <= WAIT_BUSY;
              timer <= '0;
            end
          end
        end
        WAIT_BUSY: begin
          // An engine that never raises busy (empty/invalid message) must not stall the stream.
          if (busy_ext[cur_sel])                   state <= WAIT_DONE;
          else if (timer == TW'(BUSY_TIMEOUT - 1)) state <= IDLE;
          else                                     timer <= timer + 1'b1;
        end
        WAIT_DONE: begin
          if (!busy_ext[cur_sel]) state <= IDLE;
        end
        DROP: begin
          if (!empty && (head_data == START_DECRYPTION_TOKEN)) begin
            dropped_o <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
